// File: rtl/ili9341_link_arbiter.sv
// ILI9341 SPI link owner: panel reset sequence, then cmd/pixel arbitration onto a byte serializer.
// Optional ILI_CS_TOGGLE_EN: per-command CS framing inside command transactions.
module ili9341_link_arbiter #(
  parameter int RST_LOW_CYCLES  = 60,
  parameter int RST_WAIT_CYCLES = 720000,
  parameter int CS_GAP_CYCLES   = 2,
  parameter int DLY_W           = 20
) (
  input  logic             sysclk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_data,
  input  logic             cmd_dc,
  input  logic             cmd_last,
  input  logic             cmd_delay,
  input  logic [DLY_W-1:0] cmd_dly,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [15:0]      pix_data,
  input  logic             pix_last,
  output logic             spi_valid,
  input  logic             spi_ready,
  output logic [7:0]       spi_data,
  output logic             spi_dc,
  input  logic             spi_busy,
  output logic             tft_cs,
  output logic             tft_rst,
  output logic             init_done,
  output logic             busy
);

  typedef enum logic [3:0] {
    S_RST_LOW, S_RST_WAIT, S_IDLE, S_CMD, S_DELAY,
    S_PIX_HI, S_PIX_LO, S_DRAIN, S_GAP
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [31:0]      r_tmr;
  logic [DLY_W-1:0] r_dly;
  logic             r_dly_last;
  logic [7:0]       r_pix_lo;
  logic             r_pix_last;
  logic             r_resume;
  logic             r_spi_valid, r_spi_dc;
  logic [7:0]       r_spi_data;
  logic             r_cs, r_tft_rst, r_init_done;

  logic             w_can_load, w_load, w_load_dc, w_split;
  logic [7:0]       w_load_data;
  logic             w_cmd_ready, w_pix_ready;

  assign w_can_load = !r_spi_valid || spi_ready;

`ifdef ILI_CS_TOGGLE_EN
  // A command byte after the first beat closes the current CS frame first.
  logic r_first;
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n)                                 r_first <= 1'b0;
    else if (r_state == S_IDLE || r_state == S_GAP) r_first <= 1'b1;
    else if (w_cmd_ready)                       r_first <= 1'b0;
  end
  assign w_split = (r_state == S_CMD) && cmd_valid && !cmd_delay && !cmd_dc && !r_first;
`else
  assign w_split = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_data = 8'h00;
    w_load_dc   = 1'b0;
    w_cmd_ready = 1'b0;
    w_pix_ready = 1'b0;
    case (r_state)
      S_RST_LOW:  if (r_tmr == 32'(RST_LOW_CYCLES - 1)) w_state_nxt = S_RST_WAIT;
      S_RST_WAIT: if (r_tmr == 32'(RST_WAIT_CYCLES - 1)) w_state_nxt = S_IDLE;
      S_IDLE: begin
        if (cmd_valid)      w_state_nxt = S_CMD;
        else if (pix_valid) w_state_nxt = S_PIX_HI;
      end
      S_CMD: begin
        if (w_split) begin
          w_state_nxt = S_DRAIN;
        end else if (cmd_valid && w_can_load) begin
          w_cmd_ready = 1'b1;
          if (cmd_delay) begin
            w_state_nxt = S_DELAY;
          end else begin
            w_load      = 1'b1;
            w_load_data = cmd_data;
            w_load_dc   = cmd_dc;
            if (cmd_last) w_state_nxt = S_DRAIN;
          end
        end
      end
      S_DELAY: if (r_dly == '0) w_state_nxt = r_dly_last ? S_DRAIN : S_CMD;
      S_PIX_HI: begin
        if (pix_valid && w_can_load) begin
          w_pix_ready = 1'b1;
          w_load      = 1'b1;
          w_load_data = pix_data[15:8];
          w_load_dc   = 1'b1;
          w_state_nxt = S_PIX_LO;
        end
      end
      S_PIX_LO: begin
        if (w_can_load) begin
          w_load      = 1'b1;
          w_load_data = r_pix_lo;
          w_load_dc   = 1'b1;
          w_state_nxt = r_pix_last ? S_DRAIN : S_PIX_HI;
        end
      end
      S_DRAIN: if (!r_spi_valid && !spi_busy) w_state_nxt = S_GAP;
      S_GAP:   if (r_tmr == 32'(CS_GAP_CYCLES - 1)) w_state_nxt = r_resume ? S_CMD : S_IDLE;
      default: w_state_nxt = S_RST_LOW;
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_RST_LOW;
      r_tmr       <= '0;
      r_dly       <= '0;
      r_dly_last  <= 1'b0;
      r_pix_lo    <= 8'h00;
      r_pix_last  <= 1'b0;
      r_resume    <= 1'b0;
      r_spi_valid <= 1'b0;
      r_spi_data  <= 8'h00;
      r_spi_dc    <= 1'b0;
      r_cs        <= 1'b1;
      r_tft_rst   <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // Shared timer restarts on every state change
      r_tmr   <= (w_state_nxt != r_state) ? '0 : r_tmr + 32'd1;

      if (r_state == S_RST_LOW && w_state_nxt == S_RST_WAIT) r_tft_rst   <= 1'b1;
      if (r_state == S_RST_WAIT && w_state_nxt == S_IDLE)    r_init_done <= 1'b1;

      if ((r_state == S_IDLE || r_state == S_GAP) &&
          (w_state_nxt == S_CMD || w_state_nxt == S_PIX_HI))
        r_cs <= 1'b0;
      else if (r_state == S_DRAIN && w_state_nxt == S_GAP)
        r_cs <= 1'b1;

      if (w_split)                                    r_resume <= 1'b1;
      else if (r_state == S_GAP && w_state_nxt != S_GAP) r_resume <= 1'b0;

      if (w_cmd_ready && cmd_delay) begin
        r_dly      <= cmd_dly;
        r_dly_last <= cmd_last;
      end else if (r_state == S_DELAY && r_dly != '0) begin
        r_dly <= r_dly - DLY_W'(1);
      end

      if (w_pix_ready) begin
        r_pix_lo   <= pix_data[7:0];
        r_pix_last <= pix_last;
      end

      // Output register: hold under backpressure, reload while draining
      if (w_load) begin
        r_spi_valid <= 1'b1;
        r_spi_data  <= w_load_data;
        r_spi_dc    <= w_load_dc;
      end else if (spi_ready) begin
        r_spi_valid <= 1'b0;
      end
    end
  end

  assign cmd_ready = w_cmd_ready;
  assign pix_ready = w_pix_ready;
  assign spi_valid = r_spi_valid;
  assign spi_data  = r_spi_data;
  assign spi_dc    = r_spi_dc;
  assign tft_cs    = r_cs;
  assign tft_rst   = r_tft_rst;
  assign init_done = r_init_done;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_ili9341_link_arbiter.sv
// Bench for ili9341_link_arbiter: vector tables, hand-written corner sequences and
// randomized dual-port traffic checked against a transaction-level CS-burst model.
module tb_ili9341_link_arbiter;
  localparam int RLOW  = 60;
  localparam int RWAIT = 300;
  localparam int GAP   = 2;
  localparam int DW    = 20;

  logic          sysclk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_dc, cmd_last, cmd_delay;
  logic [7:0]    cmd_data;
  logic [DW-1:0] cmd_dly;
  logic          pix_valid, pix_ready, pix_last;
  logic [15:0]   pix_data;
  logic          spi_valid, spi_ready, spi_dc, spi_busy;
  logic [7:0]    spi_data;
  logic          tft_cs, tft_rst, init_done, busy;

  always #5 sysclk = ~sysclk;

  ili9341_link_arbiter #(
    .RST_LOW_CYCLES(RLOW), .RST_WAIT_CYCLES(RWAIT), .CS_GAP_CYCLES(GAP), .DLY_W(DW)
  ) dut (
    .sysclk(sysclk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data), .cmd_dc(cmd_dc),
    .cmd_last(cmd_last), .cmd_delay(cmd_delay), .cmd_dly(cmd_dly),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_last(pix_last),
    .spi_valid(spi_valid), .spi_ready(spi_ready), .spi_data(spi_data), .spi_dc(spi_dc),
    .spi_busy(spi_busy), .tft_cs(tft_cs), .tft_rst(tft_rst), .init_done(init_done), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge sysclk) cyc <= cyc + 1;

  // Serializer model: shifts for busy_len cycles after each accepted byte
  int busy_len = 0;
  int ser_cnt = 0;
  always @(posedge sysclk) begin
    if (spi_valid && spi_ready) ser_cnt <= busy_len;
    else if (ser_cnt > 0)       ser_cnt <= ser_cnt - 1;
  end
  assign spi_busy = (ser_cnt != 0);

  bit rand_ready = 1'b0;
  bit ready_force = 1'b1;
  initial spi_ready = 1'b1;
  always @(posedge sysclk) begin
    #2;
    spi_ready = rand_ready ? ($urandom_range(0, 9) < 7) : ready_force;
  end

  // Reference model: each CS-low burst must be exactly the next transaction of one port
  logic [8:0] cmd_bytes_q[$], pix_bytes_q[$], got_q[$], cur_q[$];
  int         cmd_len_q[$], pix_len_q[$], pix_acc_q[$];

  logic       prev_cs = 1'b1, prev_valid = 1'b0, prev_busy = 1'b0, stall = 1'b0;
  logic [8:0] held = '0;
  int         high_run = 0;
  bit         ok;

  always @(negedge sysclk) begin
    if (!rst_n) begin
      cur_q.delete();
      prev_cs = 1'b1; prev_valid = 1'b0; prev_busy = 1'b0; stall = 1'b0; high_run = 0;
    end else begin
      if (stall) check("hold_under_backpressure", 32'({spi_valid, spi_dc, spi_data}), 32'({1'b1, held}));
      stall = spi_valid && !spi_ready;
      held  = {spi_dc, spi_data};
      if (spi_valid && spi_ready) begin
        check("cs_low_on_byte", 32'(tft_cs), 32'(0));
        cur_q.push_back({spi_dc, spi_data});
        got_q.push_back({spi_dc, spi_data});
      end
      if (!prev_cs && tft_cs) begin
        check("drained_before_cs_high", 32'({prev_valid, prev_busy}), 32'(0));
        ok = 1'b0;
        if (cmd_len_q.size() > 0 && cmd_len_q[0] == cur_q.size() && cmd_bytes_q.size() >= cur_q.size()) begin
          ok = 1'b1;
          for (int i = 0; i < cur_q.size(); i++) if (cmd_bytes_q[i] != cur_q[i]) ok = 1'b0;
          if (ok) begin
            for (int i = 0; i < cur_q.size(); i++) void'(cmd_bytes_q.pop_front());
            void'(cmd_len_q.pop_front());
          end
        end
        if (!ok && pix_len_q.size() > 0 && pix_len_q[0] == cur_q.size() && pix_bytes_q.size() >= cur_q.size()) begin
          ok = 1'b1;
          for (int i = 0; i < cur_q.size(); i++) if (pix_bytes_q[i] != cur_q[i]) ok = 1'b0;
          if (ok) begin
            for (int i = 0; i < cur_q.size(); i++) void'(pix_bytes_q.pop_front());
            void'(pix_len_q.pop_front());
          end
        end
        check("burst_matches_transaction", 32'(ok), 32'(1));
        cur_q.delete();
      end
      if (prev_cs && !tft_cs && high_run > 0) check("cs_gap_min", 32'(high_run >= GAP), 32'(1));
      high_run = tft_cs ? high_run + 1 : 0;
      prev_cs = tft_cs; prev_valid = spi_valid; prev_busy = spi_busy;
    end
  end

  task automatic cmd_beat(input logic [7:0] d, input logic dc, input logic last,
                          input logic dly_en, input logic [DW-1:0] dly);
    int n;
    cmd_data = d; cmd_dc = dc; cmd_last = last; cmd_delay = dly_en; cmd_dly = dly;
    cmd_valid = 1'b1;
    n = 0;
    @(negedge sysclk);
    while (!cmd_ready && n < 5000) begin @(negedge sysclk); n++; end
    if (!cmd_ready) check("cmd_ready_timeout", 32'(0), 32'(1));
    @(posedge sysclk); #1;
    cmd_valid = 1'b0; cmd_last = 1'b0; cmd_delay = 1'b0;
  endtask

  task automatic pix_beat(input logic [15:0] d, input logic last);
    int n;
    pix_data = d; pix_last = last; pix_valid = 1'b1;
    n = 0;
    @(negedge sysclk);
    while (!pix_ready && n < 5000) begin @(negedge sysclk); n++; end
    if (!pix_ready) check("pix_ready_timeout", 32'(0), 32'(1));
    else pix_acc_q.push_back(cyc);
    @(posedge sysclk); #1;
    pix_valid = 1'b0; pix_last = 1'b0;
  endtask

  task automatic wait_quiet();
    int n = 0;
    while (!(cmd_len_q.size() == 0 && pix_len_q.size() == 0 && !busy) && n < 5000) begin
      @(negedge sysclk); n++;
    end
    if (n >= 5000) check("quiet_timeout", 32'(0), 32'(1));
    @(posedge sysclk); #1;
  endtask

  task automatic reset_seq();
    int n_low = 0, n_wait = 0;
    bit rdy_seen = 1'b0;
    @(posedge sysclk); #1;
    rst_n = 1'b1;
    cmd_valid = 1'b1; cmd_data = 8'h55; pix_valid = 1'b1; pix_data = 16'h1234;
    @(negedge sysclk);
    while (!tft_rst && n_low < 1000) begin
      rdy_seen |= (cmd_ready || pix_ready); n_low++; @(negedge sysclk);
    end
    check("tft_rst_low_cycles", 32'(n_low), 32'(RLOW));
    while (!init_done && n_wait < 5000) begin
      rdy_seen |= (cmd_ready || pix_ready); n_wait++; @(negedge sysclk);
    end
    cmd_valid = 1'b0; pix_valid = 1'b0;
    check("init_wait_cycles", 32'(n_wait), 32'(RWAIT));
    check("no_ready_before_init", 32'(rdy_seen), 32'(0));
    @(posedge sysclk); #1;
    check("idle_state", 32'({busy, tft_cs, tft_rst}), 32'(3'b011));
  endtask

  task automatic rand_cmd_tx();
    int nb, len;
    logic [7:0] d[4]; logic dc[4]; logic isd[4]; logic [DW-1:0] dl[4];
    nb = $urandom_range(1, 4); len = 0;
    for (int i = 0; i < nb; i++) begin
      isd[i] = (i > 0) && ($urandom_range(0, 3) == 0);
      d[i]   = 8'($urandom);
      dc[i]  = (i == 0) ? 1'b0 : 1'($urandom);
      dl[i]  = DW'($urandom_range(0, 6));
      if (!isd[i]) begin cmd_bytes_q.push_back({dc[i], d[i]}); len++; end
    end
    cmd_len_q.push_back(len);
    for (int i = 0; i < nb; i++) cmd_beat(d[i], dc[i], (i == nb - 1), isd[i], dl[i]);
    repeat ($urandom_range(0, 3)) @(posedge sysclk);
    #1;
  endtask

  task automatic rand_pix_tx();
    int np;
    logic [15:0] p[3];
    np = $urandom_range(1, 3);
    for (int i = 0; i < np; i++) begin
      p[i] = 16'($urandom);
      pix_bytes_q.push_back({1'b1, p[i][15:8]});
      pix_bytes_q.push_back({1'b1, p[i][7:0]});
    end
    pix_len_q.push_back(2 * np);
    for (int i = 0; i < np; i++) pix_beat(p[i], (i == np - 1));
    repeat ($urandom_range(0, 3)) @(posedge sysclk);
    #1;
  endtask

  typedef struct { logic [7:0] d; logic dc; logic last; logic [7:0] exp_d; logic exp_dc; } cvec_t;
  typedef struct { logic [15:0] px; logic last; logic [7:0] exp_hi; logic [7:0] exp_lo; } pvec_t;
  cvec_t ctab[5];
  pvec_t ptab[2];

  initial begin
    int n_low;
    ctab[0] = '{8'h2A, 1'b0, 1'b0, 8'h2A, 1'b0};
    ctab[1] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b1};
    ctab[2] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b1};
    ctab[3] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b1};
    ctab[4] = '{8'hEF, 1'b1, 1'b1, 8'hEF, 1'b1};
    ptab[0] = '{16'hF800, 1'b0, 8'hF8, 8'h00};
    ptab[1] = '{16'h07E0, 1'b1, 8'h07, 8'hE0};

    cmd_valid = 0; cmd_data = 0; cmd_dc = 0; cmd_last = 0; cmd_delay = 0; cmd_dly = '0;
    pix_valid = 0; pix_data = 0; pix_last = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("reset_outputs",
          32'({tft_rst, tft_cs, spi_valid, spi_data, spi_dc, cmd_ready, pix_ready, init_done, busy}),
          32'({1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}));
    reset_seq();

    // Command transaction from the vector table
    busy_len = 2; got_q.delete();
    for (int i = 0; i < 5; i++) if (!(1'b0)) cmd_bytes_q.push_back({ctab[i].exp_dc, ctab[i].exp_d});
    cmd_len_q.push_back(5);
    for (int i = 0; i < 5; i++) cmd_beat(ctab[i].d, ctab[i].dc, ctab[i].last, 1'b0, '0);
    wait_quiet();
    check("cmd_byte_count", 32'(got_q.size()), 32'(5));
    for (int i = 0; i < 5; i++)
      if (i < got_q.size()) check($sformatf("cmd_byte%0d", i), 32'(got_q[i]), 32'({ctab[i].exp_dc, ctab[i].exp_d}));

    // Pixel stream from the vector table
    busy_len = 0; got_q.delete(); pix_acc_q.delete();
    for (int i = 0; i < 2; i++) begin
      pix_bytes_q.push_back({1'b1, ptab[i].exp_hi});
      pix_bytes_q.push_back({1'b1, ptab[i].exp_lo});
    end
    pix_len_q.push_back(4);
    for (int i = 0; i < 2; i++) pix_beat(ptab[i].px, ptab[i].last);
    wait_quiet();
    check("pix_byte_count", 32'(got_q.size()), 32'(4));
    for (int i = 0; i < 2; i++) begin
      if (2 * i + 1 < got_q.size()) begin
        check($sformatf("pix%0d_hi", i), 32'(got_q[2*i]), 32'({1'b1, ptab[i].exp_hi}));
        check($sformatf("pix%0d_lo", i), 32'(got_q[2*i+1]), 32'({1'b1, ptab[i].exp_lo}));
      end
    end
    if (pix_acc_q.size() == 2) check("pix_ready_spacing", 32'(pix_acc_q[1] - pix_acc_q[0]), 32'(2));
    else check("pix_ready_pulses", 32'(pix_acc_q.size()), 32'(2));

    // Contention: command must win, pixel follows after the gap
    busy_len = 1; got_q.delete();
    cmd_bytes_q.push_back({1'b0, 8'h2C}); cmd_len_q.push_back(1);
    pix_bytes_q.push_back({1'b1, 8'hAB}); pix_bytes_q.push_back({1'b1, 8'hCD}); pix_len_q.push_back(2);
    fork
      cmd_beat(8'h2C, 1'b0, 1'b1, 1'b0, '0);
      pix_beat(16'hABCD, 1'b1);
    join
    wait_quiet();
    check("contention_count", 32'(got_q.size()), 32'(3));
    if (got_q.size() == 3) begin
      check("contention_first_cmd", 32'(got_q[0]), 32'({1'b0, 8'h2C}));
      check("contention_then_pix", 32'(got_q[1]), 32'({1'b1, 8'hAB}));
    end

    // Backpressure for 5 cycles mid-stream
    busy_len = 0; got_q.delete();
    for (int i = 0; i < 3; i++) begin
      pix_bytes_q.push_back({1'b1, 8'(8'h10 + i)}); pix_bytes_q.push_back({1'b1, 8'(8'hA0 + i)});
    end
    pix_len_q.push_back(6);
    fork
      for (int i = 0; i < 3; i++) pix_beat({8'(8'h10 + i), 8'(8'hA0 + i)}, (i == 2));
      begin
        int n = 0;
        while (got_q.size() < 2 && n < 1000) begin @(negedge sysclk); n++; end
        ready_force = 1'b0;
        repeat (6) @(posedge sysclk);
        ready_force = 1'b1;
      end
    join
    wait_quiet();
    check("backpressure_count", 32'(got_q.size()), 32'(6));

    // Delay beat with last: CS stays low through the wait
    got_q.delete();
    cmd_bytes_q.push_back({1'b0, 8'h11}); cmd_len_q.push_back(1);
    cmd_beat(8'h11, 1'b0, 1'b0, 1'b0, '0);
    cmd_beat(8'hFF, 1'b1, 1'b1, 1'b1, DW'(100));
    n_low = 0;
    while (!tft_cs && n_low < 300) begin @(negedge sysclk); n_low++; end
    check("delay_cs_low_min", 32'(n_low >= 100), 32'(1));
    check("delay_cs_low_max", 32'(n_low <= 105), 32'(1));
    wait_quiet();

    // Randomized traffic on both ports
    rand_ready = 1'b1; busy_len = 1;
    fork
      for (int k = 0; k < 12; k++) rand_cmd_tx();
      for (int k = 0; k < 12; k++) rand_pix_tx();
    join
    rand_ready = 1'b0; ready_force = 1'b1;
    wait_quiet();

    // Reset while stuck in PIX_LO
    ready_force = 1'b0;
    repeat (2) @(posedge sysclk);
    #1;
    pix_beat(16'h5A5A, 1'b0);
    check("stuck_in_pix_lo", 32'({spi_valid, tft_cs, busy}), 32'(3'b101));
    rst_n = 1'b0;
    #1;
    check("midop_reset_outputs", 32'({tft_cs, spi_valid, tft_rst, init_done, busy}), 32'(5'b10001));
    ready_force = 1'b1;
    reset_seq();

    got_q.delete();
    cmd_bytes_q.push_back({1'b0, 8'h29}); cmd_len_q.push_back(1);
    cmd_beat(8'h29, 1'b0, 1'b1, 1'b0, '0);
    wait_quiet();
    check("post_reset_cmd", 32'(got_q.size() > 0 ? got_q[0] : 9'h1FF), 32'({1'b0, 8'h29}));
    check("cmd_model_empty", 32'(cmd_len_q.size()), 32'(0));
    check("pix_model_empty", 32'(pix_len_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
